regfile_block_xfer_seq: RTL

- Sequencer for ARM LDM/STM block transfers: walks a 16-bit register list and drives the register file's read/write ports and a single-outstanding memory request port, one register per transfer.
- Sits between the control unit (issues `start` with decoded fields) and the 16x32 register file plus data-memory interface.
- Owns the register file ports only while `busy` is high.

---
 rtl/regfile_block_xfer_seq.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/regfile_block_xfer_seq.sv
// regfile_block_xfer_seq: ARM LDM/STM block-transfer sequencer.
// Walks a 16-bit register list lowest-first. Each register gets one memory
// request, and a load adds one register-file write cycle. The block owns the
// register-file write port only while busy is high.
// Optional build macro LDMSEQ_TIMEOUT_EN: aborts a stalled memory request
// after TIMEOUT_CYCLES cycles and raises err.
module regfile_block_xfer_seq #(
   parameter int unsigned ADDR_STEP      = 4,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        start,
   input  logic        is_load,
   input  logic        up,
   input  logic        pre,
   input  logic        wback,
   input  logic [3:0]  rn,
   input  logic [15:0] reg_list,
   input  logic [31:0] rf_outA,
   input  logic [31:0] rf_outB,
   output logic [3:0]  rf_readA,
   output logic [3:0]  rf_readB,
   output logic [3:0]  rf_writeA,
   output logic [31:0] rf_dataIn,
   output logic        rf_enable,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_done,
   output logic        busy,
   output logic        done,
   output logic        err
);

   typedef enum logic [2:0] {S_IDLE, S_XFER, S_LWR, S_WB, S_DONE} state_t;

   state_t      state_q;
   logic [15:0] list_q;
   logic [3:0]  cur_q, rn_q, rf_readA_q, rf_writeA_q;
   logic [31:0] mem_addr_q, final_q, rf_dataIn_q;
   logic        is_load_q, wb_do_q, rf_enable_q, mem_req_q, mem_we_q, busy_q, done_q;

   // Index of the lowest set bit; 0 for an empty list.
   function automatic logic [3:0] lowest_idx(input logic [15:0] l);
      logic [3:0] idx;
      idx = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (l[i]) idx = 4'(i);
      end
      return idx;
   endfunction

   function automatic logic [4:0] pop16(input logic [15:0] l);
      logic [4:0] cnt;
      cnt = 5'd0;
      for (int i = 0; i < 16; i++) cnt = cnt + 5'(l[i]);
      return cnt;
   endfunction

   logic [4:0]  n_start;
   logic [31:0] span, start_addr, final_start;
   logic        wb_start;
   logic [15:0] list_d;
   logic [3:0]  cur_d, cur_rem;

   // Start-of-block address arithmetic and the walk of the remaining list.
   always_comb begin
      n_start     = pop16(reg_list);
      span        = 32'(ADDR_STEP) * 32'(n_start);
      final_start = up ? rf_outB + span : rf_outB - span;
      case ({up, pre})
         2'b11:   start_addr = rf_outB + 32'(ADDR_STEP);
         2'b10:   start_addr = rf_outB;
         2'b01:   start_addr = rf_outB - span;
         default: start_addr = rf_outB - span + 32'(ADDR_STEP);
      endcase
      // A loaded base register wins over the writeback value.
      wb_start = wback & ~(is_load & reg_list[rn]);
      list_d   = list_q & ~(16'd1 << cur_q);
      cur_d    = lowest_idx(list_d);
      cur_rem  = lowest_idx(list_q);
   end

`ifdef LDMSEQ_TIMEOUT_EN
   localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [TMO_W-1:0] tmo_q;
   logic             err_q;
   logic             tmo_hit;

   assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
   assign err     = err_q;

   // Cycles spent waiting on the current request; restarts with every new request.
   always_ff @(posedge clk) begin
      if (clr || state_q != S_XFER || mem_done) tmo_q <= '0;
      else                                      tmo_q <= tmo_q + TMO_W'(1);
   end
`else
   logic unused_tmo;
   assign unused_tmo = ^32'(TIMEOUT_CYCLES);
   assign err        = 1'b0;
`endif

   // Sequencer FSM with registered register-file and memory controls.
   always_ff @(posedge clk) begin
      if (clr) begin
         state_q     <= S_IDLE;
         list_q      <= '0;
         cur_q       <= '0;
         rn_q        <= '0;
         rf_readA_q  <= '0;
         rf_writeA_q <= '0;
         rf_dataIn_q <= '0;
         mem_addr_q  <= '0;
         final_q     <= '0;
         is_load_q   <= 1'b0;
         wb_do_q     <= 1'b0;
         rf_enable_q <= 1'b1;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
`ifdef LDMSEQ_TIMEOUT_EN
         err_q       <= 1'b0;
`endif
      end else begin
         rf_enable_q <= 1'b1;
         done_q      <= 1'b0;
         case (state_q)
            S_IDLE: begin
               busy_q    <= 1'b0;
               mem_req_q <= 1'b0;
               if (start) begin
                  list_q     <= reg_list;
                  rn_q       <= rn;
                  is_load_q  <= is_load;
                  wb_do_q    <= wb_start;
                  final_q    <= final_start;
                  mem_addr_q <= start_addr;
                  mem_we_q   <= ~is_load;
                  cur_q      <= lowest_idx(reg_list);
                  rf_readA_q <= lowest_idx(reg_list);
                  busy_q     <= 1'b1;
`ifdef LDMSEQ_TIMEOUT_EN
                  err_q      <= 1'b0;
`endif
                  if (reg_list == 16'd0) begin
                     state_q     <= S_WB;
                     rf_enable_q <= ~wb_start;
                     rf_writeA_q <= rn;
                     rf_dataIn_q <= final_start;
                  end else begin
                     state_q   <= S_XFER;
                     mem_req_q <= 1'b1;
                  end
               end
            end
            S_XFER: begin
               if (mem_done) begin
                  list_q     <= list_d;
                  mem_addr_q <= mem_addr_q + 32'(ADDR_STEP);
                  if (is_load_q) begin
                     state_q     <= S_LWR;
                     mem_req_q   <= 1'b0;
                     rf_enable_q <= 1'b0;
                     rf_writeA_q <= cur_q;
                     rf_dataIn_q <= mem_rdata;
                  end else if (list_d != 16'd0) begin
                     cur_q      <= cur_d;
                     rf_readA_q <= cur_d;
                  end else begin
                     state_q     <= S_WB;
                     mem_req_q   <= 1'b0;
                     rf_enable_q <= ~wb_do_q;
                     rf_writeA_q <= rn_q;
                     rf_dataIn_q <= final_q;
                  end
               end
`ifdef LDMSEQ_TIMEOUT_EN
               else if (tmo_hit) begin
                  err_q     <= 1'b1;
                  mem_req_q <= 1'b0;
                  done_q    <= 1'b1;
                  state_q   <= S_DONE;
               end
`endif
            end
            S_LWR: begin
               if (list_q != 16'd0) begin
                  state_q    <= S_XFER;
                  mem_req_q  <= 1'b1;
                  cur_q      <= cur_rem;
                  rf_readA_q <= cur_rem;
               end else begin
                  state_q     <= S_WB;
                  rf_enable_q <= ~wb_do_q;
                  rf_writeA_q <= rn_q;
                  rf_dataIn_q <= final_q;
               end
            end
            S_WB: begin
               state_q <= S_DONE;
               done_q  <= 1'b1;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // A reset arriving during a write cycle must cancel that write.
   assign rf_enable = rf_enable_q | clr;
   assign rf_readA  = rf_readA_q;
   assign rf_readB  = rn;
   assign rf_writeA = rf_writeA_q;
   assign rf_dataIn = rf_dataIn_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = rf_outA;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule
